conv_encoder_sys: RTL and testbench
===================================

# conv_encoder_sys

Rate-1/2 feed-forward convolutional encoder that produces the two-bit symbol stream consumed by the Viterbi decoder. It accepts a frame of FRAME_LEN information bits through a valid/ready handshake and emits one encoded_bits symbol per accepted bit. It then appends K-1 zero tail bits so the decoder trellis terminates in state 0. The constraint length K (3–6) is chosen per frame.

## Interface
- FRAME_LEN, 13: information bits per frame. With K=3 a frame is 15 symbols, matching the decoder trellis depth.
- K_MAX, 6: largest supported constraint length. Sets the shift-register width to K_MAX-1.
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset, synchronous, active-high.
- in_bit  in  1  information bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  the encoder accepts in_bit this cycle.
- choose_constraint_length  in  3  K; sampled at the first accepted bit of a frame.
- encoded_bits  out  2  [1] = parity of generator g0, [0] = parity of generator g1.
- out_valid  out  1  encoded_bits is valid.
- out_ready  in  1  downstream consumes the symbol.
- out_last  out  1  high with the final tail symbol of a frame.
- busy  out  1  a frame is in progress (state ≠ IDLE or out_valid).

## Operation
- Generators (octal, MSB tap = current input): K=3 (7,5), K=4 (15,17), K=5 (23,35), K=6 (53,75).
- choose_constraint_length values 0–2 or 7 are treated as K=3.
- Shift register sr[K_MAX-2:0], with sr[0] the most recent past bit. Tap vector = {in, sr[0], sr[1], …}, masked to K bits. Each parity is the XOR of the masked taps with the generator.
- FSM states:
  - IDLE: sr=0, bit_cnt=0. The first accepted bit latches K_r and moves to DATA.
  - DATA: each accepted bit is encoded, sr shifts and bit_cnt increments. When the FRAME_LEN-th bit is accepted, tail_cnt is set to K_r-1 and the FSM moves to TAIL.
  - TAIL: in_ready=0. A 0 bit is encoded internally each time the output slot is free, and tail_cnt decrements. The last tail symbol carries out_last=1. The FSM returns to IDLE with sr cleared.
- K_r is held for the whole frame; changes to choose_constraint_length mid-frame have no effect until the next IDLE→DATA transition.
- Frame length is FRAME_LEN + K_r − 1 symbols.

## Timing
- Reset values: in_ready=0 during the rst cycle and 1 afterwards in IDLE. encoded_bits=2'b00, out_valid=0, out_last=0, busy=0, sr=0, state=IDLE.
- in_ready = (state∈{IDLE,DATA}) && (!out_valid || out_ready).
- A bit is accepted when in_valid && in_ready. Its symbol is registered and shows out_valid=1 on the next cycle (latency 1).
- out_valid stays high with encoded_bits stable until out_ready is sampled high.
- A simultaneous consume and accept loads the new symbol with no bubble. The TAIL output slot refills the same way.
- Sustained in_valid=out_ready=1 gives 1 symbol/cycle with no gap between DATA and TAIL, and an idle gap of at least 1 cycle between frames. The next frame's first bit can be accepted in the cycle after the FSM returns to IDLE.
- in_valid low in DATA inserts output bubbles; sr and the counters hold.
- rst mid-frame discards the partial frame. No out_last is produced, and the first symbol after reset belongs to a new frame with sr=0.

## Structure
- Package conv_code_pkg:
  - K_MIN=3 and K_MAX=6.
  - gen_poly(K) function returning {g0,g1}.
  - enc_state_t enum {IDLE, DATA, TAIL}.
  - sanitize_k() function.
- Sub-module conv_parity: combinational, taking tap vector and K and returning encoded_bits. The decoder reuses it for branch-output generation.

## Test plan
- K=3, frame 1,0,1,1,0×9 with out_ready=1 → symbols 11,10,00,01,01,11,00… ending in 2 tail symbols, 15 total, out_last on the 15th only.
- K=3, impulse 1,0×12 → 11,10,11 then 00×12. K=4, same impulse → 11,11,01,11 then 00×12, 16 symbols.
- All-zero frame at K=6 → 18 symbols of 00, out_last on the 18th. choose_constraint_length=7 → 15 symbols, same as K=3.
- Backpressure: toggle out_ready 1/0 every cycle → encoded_bits stable while stalled, in_ready=0 whenever out_valid && !out_ready, symbol sequence identical to the unstalled run.
- Change choose_constraint_length 3→5 after bit 4 → frame still 15 symbols. The next frame uses K=5 (17 symbols).
- Assert rst at bit 7 → outputs at reset values next cycle. A new impulse frame then yields 11,10,11 (sr cleared).

Source files
------------

// File: rtl/conv_code_pkg.sv
// conv_code_pkg: shared constants, FSM state type and generator helpers for the convolutional code
package conv_code_pkg;
  localparam int K_MIN = 3;
  localparam int K_MAX = 6;
  typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;
  // Out-of-range constraint lengths fall back to the shortest code.
  function automatic logic [2:0] sanitize_k(input logic [2:0] k);
    return (k >= 3'(K_MIN) && k <= 3'(K_MAX)) ? k : 3'(K_MIN);
  endfunction
  // Returns {g0,g1}, each left-aligned in K_MAX bits so the MSB always taps the current input
  // and taps beyond K are zero.
  function automatic logic [2*K_MAX-1:0] gen_poly(input logic [2:0] k);
    return k == 3'd6 ? {6'o53, 6'o75} :
           k == 3'd5 ? {6'o46, 6'o72} :
           k == 3'd4 ? {6'o64, 6'o74} : {6'o70, 6'o50};
  endfunction
endpackage

// File: rtl/conv_encoder_sys_if.sv
// conv_encoder_sys_if: input bit stream, encoded symbol stream and status of the encoder
interface conv_encoder_sys_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] choose_constraint_length;
  logic [1:0] encoded_bits;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  modport master (output in_bit, in_valid, choose_constraint_length, out_ready,
                  input in_ready, encoded_bits, out_valid, out_last, busy);
  modport slave (input in_bit, in_valid, choose_constraint_length, out_ready,
                 output in_ready, encoded_bits, out_valid, out_last, busy);
endinterface

// File: rtl/conv_parity.sv
// conv_parity: two generator parities of a left-aligned tap vector for constraint length K
module conv_parity
  import conv_code_pkg::*;
(
  input  logic [K_MAX-1:0] i_taps,
  input  logic [2:0]       i_k,
  output logic [1:0]       o_bits
);
  logic [2*K_MAX-1:0] w_g;
  assign w_g = gen_poly(i_k);
  assign o_bits = {^(i_taps & w_g[2*K_MAX-1:K_MAX]), ^(i_taps & w_g[K_MAX-1:0])};
endmodule

// File: rtl/conv_encoder_sys.sv
// conv_encoder_sys: rate-1/2 framed convolutional encoder with zero-tail termination
module conv_encoder_sys
  import conv_code_pkg::*;
#(
  parameter int FRAME_LEN = 13
) (
  input logic clk,
  input logic rst,
  conv_encoder_sys_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  enc_state_t       r_state, w_next;
  logic [K_MAX-2:0] r_sr;
  logic [CW-1:0]    r_bit_cnt;
  logic [2:0]       r_tail_cnt, r_k, w_k;
  logic [1:0]       r_enc, w_enc;
  logic             r_valid, r_last;
  logic             w_slot_free, w_in_ready, w_busy, w_accept, w_tail_fire, w_last_bit, w_last_tail, w_bit;
  logic [K_MAX-1:0] w_taps;
  assign w_slot_free = !r_valid || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_tail_fire = r_state == TAIL && w_slot_free;
  assign w_last_bit  = r_state == DATA && w_accept && r_bit_cnt == CW'(FRAME_LEN - 1);
  assign w_last_tail = w_tail_fire && r_tail_cnt == 3'd1;
  assign w_bit       = w_tail_fire ? 1'b0 : bus.in_bit;
  assign w_k         = r_state == IDLE ? sanitize_k(bus.choose_constraint_length) : r_k;
  // Tap vector {bit, sr[0], sr[1], ...}: the shift register is reversed into the low taps.
  always_comb begin
    w_taps = {w_bit, {(K_MAX-1){1'b0}}};
    for (int i = 0; i < K_MAX - 1; i++) w_taps[K_MAX-2-i] = r_sr[i];
  end
  conv_parity u_parity (.i_taps(w_taps), .i_k(w_k), .o_bits(w_enc));
  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // FSM next state: first bit opens a frame, last data bit enters the tail, last tail symbol closes it
  always_comb begin
    w_next = (r_state == IDLE && w_accept) ? DATA :
             w_last_bit                    ? TAIL :
             w_last_tail                   ? IDLE : r_state;
  end
  // FSM outputs: accept input only outside the tail and when the output slot is free or draining
  always_comb begin
    w_in_ready = !rst && r_state != TAIL && w_slot_free;
    w_busy     = r_state != IDLE || r_valid;
  end
  // Datapath: shift register, counters, latched K and the registered output symbol
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_tail_cnt <= '0;
      r_k        <= 3'(K_MIN);
      r_enc      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sr      <= {r_sr[K_MAX-3:0], bus.in_bit};
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
      end
      if (r_state == IDLE && w_accept) r_k <= w_k;
      if (w_last_bit) r_tail_cnt <= r_k - 3'd1;
      if (w_tail_fire) begin
        r_sr       <= w_last_tail ? '0 : {r_sr[K_MAX-3:0], 1'b0};
        r_tail_cnt <= r_tail_cnt - 3'd1;
      end
      if (w_accept || w_tail_fire) begin
        r_enc   <= w_enc;
        r_valid <= 1'b1;
        r_last  <= w_last_tail;
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end
  assign bus.in_ready     = w_in_ready;
  assign bus.busy         = w_busy;
  assign bus.encoded_bits = r_enc;
  assign bus.out_valid    = r_valid;
  assign bus.out_last     = r_last;
endmodule

// File: tb/tb_conv_encoder_sys.sv
// tb_conv_encoder_sys: scoreboard bench for the framed convolutional encoder
module tb_conv_encoder_sys;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int viol = 0;
  bit timed_out = 1'b0;
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  conv_encoder_sys_if bus();
  conv_encoder_sys #(.FRAME_LEN(13)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference encoder: reg bit k-1 is the current input, bit k-2 the most recent past bit.
  function automatic void model(input logic [12:0] bits, input int k);
    int g0, g1, r, sr;
    g0 = k == 6 ? 'o53 : k == 5 ? 'o23 : k == 4 ? 'o15 : 'o7;
    g1 = k == 6 ? 'o75 : k == 5 ? 'o35 : k == 4 ? 'o17 : 'o5;
    sr = 0;
    for (int i = 0; i < 13 + k - 1; i++) begin
      r = ((i < 13 ? int'(bits[i]) : 0) << (k - 1)) | sr;
      exp_q.push_back({^(r & g0), ^(r & g1), i == 13 + k - 2});
      sr = r >> 1;
    end
  endfunction
  function automatic void push_sym(input logic [1:0] s, input logic last);
    exp_q.push_back({s, last});
  endfunction
  // Drives one frame and records every consumed symbol; stops at out_last or at abort_at accepted bits.
  task automatic run_frame(input logic [12:0] bits, input logic [2:0] kc, input logic [2:0] kc_late,
                           input int k_change_at, input bit toggle, input int abort_at);
    int idx = 0;
    bit done = 1'b0;
    bit stopped = 1'b0;
    bit was_stalled = 1'b0;
    logic [1:0] prev = 2'b00;
    obs_q.delete();
    viol = 0;
    for (int cyc = 0; cyc < 300 && !done && !stopped; cyc++) begin
      @(negedge clk);
      bus.choose_constraint_length = idx >= k_change_at ? kc_late : kc;
      bus.in_valid  = idx < 13;
      bus.in_bit    = idx < 13 ? bits[idx] : 1'b0;
      bus.out_ready = toggle ? cyc[0] : 1'b1;
      #1;
      if (was_stalled && (!bus.out_valid || bus.encoded_bits !== prev)) viol++;
      if (bus.out_valid && !bus.out_ready && bus.in_ready) viol++;
      was_stalled = bus.out_valid && !bus.out_ready;
      prev = bus.encoded_bits;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back({bus.encoded_bits, bus.out_last});
        if (bus.out_last) done = 1'b1;
      end
      if (abort_at >= 0 && idx == abort_at) stopped = 1'b1;
    end
    timed_out = !done && !stopped;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.out_ready = 1'b1;
    bus.choose_constraint_length = 3'd3;
    repeat (2) @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.encoded_bits !== 2'b00) begin fails++; $display("FAIL reset_encoded: got %b expected 00", bus.encoded_bits); end
    tests++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
  endtask
  task automatic test_k3_frame();
    int n = 0;
    model(13'h000D, 3);
    run_frame(13'h000D, 3'd3, 3'd3, 99, 1'b0, -1);
    tests++; if (timed_out) begin fails++; $display("FAIL k3_timeout: got timeout expected out_last"); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL k3_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL k3_sym%0d: got %b expected %b", n, o, e); end
      n++;
    end
    exp_q.delete();
  endtask
  task automatic test_impulse();
    int n = 0;
    push_sym(2'b11, 0); push_sym(2'b10, 0); push_sym(2'b11, 0);
    for (int i = 0; i < 12; i++) push_sym(2'b00, i == 11);
    push_sym(2'b11, 0); push_sym(2'b11, 0); push_sym(2'b01, 0); push_sym(2'b11, 0);
    for (int i = 0; i < 12; i++) push_sym(2'b00, i == 11);
    run_frame(13'h0001, 3'd3, 3'd3, 99, 1'b0, -1);
    begin
      logic [2:0] tmp[$];
      tmp = obs_q;
      tests++; if (timed_out) begin fails++; $display("FAIL imp3_timeout: got timeout expected out_last"); end
      run_frame(13'h0001, 3'd4, 3'd4, 99, 1'b0, -1);
      tests++; if (timed_out) begin fails++; $display("FAIL imp4_timeout: got timeout expected out_last"); end
      tests++; if (tmp.size() != 15 || obs_q.size() != 16) begin fails++; $display("FAIL imp_len: got %0d/%0d expected 15/16", tmp.size(), obs_q.size()); end
      obs_q = {tmp, obs_q};
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL imp_sym%0d: got %b expected %b", n, o, e); end
      n++;
    end
    exp_q.delete();
  endtask
  task automatic test_zero_frames();
    int n = 0;
    model(13'h0000, 6);
    run_frame(13'h0000, 3'd6, 3'd6, 99, 1'b0, -1);
    tests++; if (obs_q.size() != 18) begin fails++; $display("FAIL k6_len: got %0d expected 18", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL k6_sym%0d: got %b expected %b", n, o, e); end
      n++;
    end
    exp_q.delete();
    run_frame(13'h0000, 3'd7, 3'd7, 99, 1'b0, -1);
    tests++; if (timed_out || obs_q.size() != 15) begin fails++; $display("FAIL k7_len: got %0d expected 15", obs_q.size()); end
  endtask
  task automatic test_backpressure();
    int n = 0;
    model(13'h1A5B, 5);
    run_frame(13'h1A5B, 3'd5, 3'd5, 99, 1'b1, -1);
    tests++; if (timed_out) begin fails++; $display("FAIL bp_timeout: got timeout expected out_last"); end
    tests++; if (viol != 0) begin fails++; $display("FAIL bp_stall_rules: got %0d violations expected 0", viol); end
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL bp_sym%0d: got %b expected %b", n, o, e); end
      n++;
    end
    exp_q.delete();
  endtask
  task automatic test_k_change();
    int n = 0;
    model(13'h0B37, 3);
    run_frame(13'h0B37, 3'd3, 3'd5, 4, 1'b0, -1);
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL kchg_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL kchg_sym%0d: got %b expected %b", n, o, e); end
      n++;
    end
    exp_q.delete();
    model(13'h0B37, 5);
    run_frame(13'h0B37, 3'd5, 3'd5, 99, 1'b0, -1);
    tests++; if (obs_q.size() != 17) begin fails++; $display("FAIL k5_len: got %0d expected 17", obs_q.size()); end
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL k5_sym%0d: got %b expected %b", n, o, e); end
      n++;
    end
    exp_q.delete();
  endtask
  task automatic test_reset_mid();
    int n = 0;
    int lasts = 0;
    run_frame(13'h1FFF, 3'd3, 3'd3, 99, 1'b0, 7);
    foreach (obs_q[i]) lasts += int'(obs_q[i][0]);
    tests++; if (timed_out || lasts != 0) begin fails++; $display("FAIL abort_last: got %0d out_last expected 0", lasts); end
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    tests++; if ({bus.out_valid, bus.out_last, bus.busy, bus.in_ready, bus.encoded_bits} !== 6'b0) begin
      fails++; $display("FAIL abort_reset_outputs: got %b expected 000000", {bus.out_valid, bus.out_last, bus.busy, bus.in_ready, bus.encoded_bits});
    end
    rst = 1'b0;
    push_sym(2'b11, 0); push_sym(2'b10, 0); push_sym(2'b11, 0);
    for (int i = 0; i < 12; i++) push_sym(2'b00, i == 11);
    run_frame(13'h0001, 3'd3, 3'd3, 99, 1'b0, -1);
    tests++; if (obs_q.size() != 15) begin fails++; $display("FAIL post_reset_len: got %0d expected 15", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [2:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      tests++; if (o !== e) begin fails++; $display("FAIL post_reset_sym%0d: got %b expected %b", n, o, e); end
      n++;
    end
    exp_q.delete();
  endtask
  initial begin
    test_reset();
    test_k3_frame();
    test_impulse();
    test_zero_frames();
    test_backpressure();
    test_k_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
